// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared state type, widths and latency helper for the RC4 key-scheduling engine
package rc4_pkg;

  localparam int KEY_BYTE_W     = 8;
  localparam int DEFAULT_ADDR_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_RD_I,
    ST_WAIT_I,
    ST_RD_J,
    ST_WAIT_J,
    ST_WR_I,
    ST_WR_J,
    ST_DONE
  } ksa_state_t;

  // Cycles from the start-acceptance edge to the done pulse.
  function automatic int ksa_latency(int n, int rd_lat, bit init_en);
    return (init_en ? n : 0) + n * (4 + 2 * rd_lat) + 1;
  endfunction

endpackage

// File: rtl/rc4_key_sel.sv
// rtl/rc4_key_sel.sv - latched key bytes with a wrapping byte index; byte 0 is the key MSB
module rc4_key_sel
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = 3
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic                            advance,
  input  logic [KEY_BYTE_W*KEY_BYTES-1:0] key,
  output logic [KEY_BYTE_W-1:0]           key_byte
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

  logic [KEY_BYTE_W-1:0] key_r [KEY_BYTES];
  logic [KIDX_W-1:0]     kidx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kidx <= '0;
      for (int b = 0; b < KEY_BYTES; b++) key_r[b] <= '0;
    end else if (load) begin
      kidx <= '0;
      for (int b = 0; b < KEY_BYTES; b++)
        key_r[b] <= key[KEY_BYTE_W*(KEY_BYTES-b)-1 -: KEY_BYTE_W];
    end else if (advance) begin
      kidx <= (kidx == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx + KIDX_W'(1);
    end
  end

  assign key_byte = key_r[kidx];

endmodule

// File: rtl/rc4_ksa_engine.sv
// rtl/rc4_ksa_engine.sv - RC4 key-scheduling engine driving a single-port S-box RAM
// Optional S[i]=i INIT phase: define RC4_KSA_INIT_EN.
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter  int N         = 256,
  parameter  int KEY_BYTES = 3,
  parameter  int RD_LAT    = 1,
  localparam int ADDR_W    = $clog2(N)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [KEY_BYTE_W*KEY_BYTES-1:0] key,
  output logic                            busy,
  output logic                            done,
  output logic                            mem_req,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [ADDR_W-1:0]               mem_wdata,
  output logic                            mem_wren,
  input  logic [ADDR_W-1:0]               mem_rdata
);

  ksa_state_t state, state_nxt;
  logic [ADDR_W-1:0] i, i_nxt, j, j_nxt, si, si_nxt, sj, sj_nxt;
  logic [ADDR_W-1:0] addr_nxt, wdata_nxt;
  logic [1:0]        lat_cnt, lat_cnt_nxt;
  logic              wren_nxt, busy_nxt, done_nxt, lat_last;
  logic              key_load, key_adv;
  logic [KEY_BYTE_W-1:0] key_byte;

  rc4_key_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (key_load),
    .advance  (key_adv),
    .key      (key),
    .key_byte (key_byte)
  );

  assign lat_last = (lat_cnt == 2'(RD_LAT - 1));

  always_comb begin
    state_nxt   = state;
    i_nxt       = i;
    j_nxt       = j;
    si_nxt      = si;
    sj_nxt      = sj;
    lat_cnt_nxt = '0;
    key_load    = 1'b0;
    key_adv     = 1'b0;
    case (state)
      ST_IDLE: if (start) begin
        key_load = 1'b1;
        i_nxt    = '0;
        j_nxt    = '0;
`ifdef RC4_KSA_INIT_EN
        state_nxt = ST_INIT;
`else
        state_nxt = ST_RD_I;
`endif
      end
`ifdef RC4_KSA_INIT_EN
      ST_INIT: begin
        i_nxt = i + ADDR_W'(1);  // wraps to 0 after N-1, ready for the swap loop
        if (i == ADDR_W'(N - 1)) state_nxt = ST_RD_I;
      end
`endif
      ST_RD_I: state_nxt = ST_WAIT_I;
      ST_WAIT_I: if (lat_last) begin
        si_nxt    = mem_rdata;
        j_nxt     = j + mem_rdata + key_byte[ADDR_W-1:0];
        state_nxt = ST_RD_J;
      end else begin
        lat_cnt_nxt = lat_cnt + 2'd1;
      end
      ST_RD_J: state_nxt = ST_WAIT_J;
      ST_WAIT_J: if (lat_last) begin
        sj_nxt    = mem_rdata;
        state_nxt = ST_WR_I;
      end else begin
        lat_cnt_nxt = lat_cnt + 2'd1;
      end
      ST_WR_I: state_nxt = ST_WR_J;
      ST_WR_J: if (i == ADDR_W'(N - 1)) begin
        state_nxt = ST_DONE;
      end else begin
        i_nxt     = i + ADDR_W'(1);
        key_adv   = 1'b1;
        state_nxt = ST_RD_I;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (abort) begin
      state_nxt = ST_IDLE;
      key_load  = 1'b0;
      key_adv   = 1'b0;
    end

    // Bus outputs are registered, so they follow the state being entered.
    addr_nxt  = '0;
    wdata_nxt = '0;
    wren_nxt  = 1'b0;
    case (state_nxt)
      ST_INIT:            begin addr_nxt = i_nxt; wdata_nxt = i_nxt;  wren_nxt = 1'b1; end
      ST_RD_I, ST_WAIT_I: addr_nxt = i_nxt;
      ST_RD_J, ST_WAIT_J: addr_nxt = j_nxt;
      ST_WR_I:            begin addr_nxt = i_nxt; wdata_nxt = sj_nxt; wren_nxt = 1'b1; end
      ST_WR_J:            begin addr_nxt = j_nxt; wdata_nxt = si_nxt; wren_nxt = 1'b1; end
      default:            addr_nxt = '0;
    endcase
    busy_nxt = !(state_nxt inside {ST_IDLE, ST_DONE});
    done_nxt = (state == ST_DONE) && !abort;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      lat_cnt   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wren  <= 1'b0;
      busy      <= 1'b0;
      mem_req   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      i         <= i_nxt;
      j         <= j_nxt;
      si        <= si_nxt;
      sj        <= sj_nxt;
      lat_cnt   <= lat_cnt_nxt;
      mem_addr  <= addr_nxt;
      mem_wdata <= wdata_nxt;
      mem_wren  <= wren_nxt;
      busy      <= busy_nxt;
      mem_req   <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb/tb_rc4_ksa_engine.sv - scoreboard bench for rc4_ksa_engine over four configurations
// Follows RC4_KSA_INIT_EN: preloads identity when undefined, scrambled RAM when defined.
module tb_rc4_ksa_engine;

`ifdef RC4_KSA_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]    inst;
    logic [31:0]   lat;
    logic [2047:0] img;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] start_v = '0, abort_v = '0;
  logic [3:0] busy_v, done_v, req_v, wren_v;
  logic [7:0]  key0 = '0;
  logic [23:0] key1 = '0, key2 = '0;
  logic [39:0] key3 = '0;
  logic [1:0] addr0, wd0, rd0;
  logic [7:0] addr1, wd1, rd1, addr2, wd2, rd2;
  logic [3:0] addr3, wd3, rd3;
  logic [7:0] addr_v [4];
  logic [7:0] wd_v [4];
  logic [7:0] ram [4][256];
  logic [7:0] p1 [4];
  logic [7:0] p2 [4];
  logic       fill_go = 1'b0;
  int         fill_k = 0;

  exp_t sb [$];
  int checks = 0, errors = 0, cyc = 0;
  int start_cyc [4];
  exp_t mon_e;
  logic [2047:0] mon_img;

  rc4_ksa_engine #(.N(4), .KEY_BYTES(1), .RD_LAT(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .abort(abort_v[0]), .key(key0),
    .busy(busy_v[0]), .done(done_v[0]), .mem_req(req_v[0]), .mem_addr(addr0),
    .mem_wdata(wd0), .mem_wren(wren_v[0]), .mem_rdata(rd0));
  rc4_ksa_engine #(.N(256), .KEY_BYTES(3), .RD_LAT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .abort(abort_v[1]), .key(key1),
    .busy(busy_v[1]), .done(done_v[1]), .mem_req(req_v[1]), .mem_addr(addr1),
    .mem_wdata(wd1), .mem_wren(wren_v[1]), .mem_rdata(rd1));
  rc4_ksa_engine #(.N(256), .KEY_BYTES(3), .RD_LAT(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .abort(abort_v[2]), .key(key2),
    .busy(busy_v[2]), .done(done_v[2]), .mem_req(req_v[2]), .mem_addr(addr2),
    .mem_wdata(wd2), .mem_wren(wren_v[2]), .mem_rdata(rd2));
  rc4_ksa_engine #(.N(16), .KEY_BYTES(5), .RD_LAT(1)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start_v[3]), .abort(abort_v[3]), .key(key3),
    .busy(busy_v[3]), .done(done_v[3]), .mem_req(req_v[3]), .mem_addr(addr3),
    .mem_wdata(wd3), .mem_wren(wren_v[3]), .mem_rdata(rd3));

  always_comb begin
    addr_v[0] = {6'd0, addr0}; wd_v[0] = {6'd0, wd0};
    addr_v[1] = addr1;         wd_v[1] = wd1;
    addr_v[2] = addr2;         wd_v[2] = wd2;
    addr_v[3] = {4'd0, addr3}; wd_v[3] = {4'd0, wd3};
  end

  assign rd0 = p1[0][1:0];
  assign rd1 = p1[1];
  assign rd2 = p2[2];
  assign rd3 = p1[3][3:0];

  // Four RAMs; instance 2 sees a two-stage read pipeline.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 4; k++) begin
      if (fill_go && fill_k == k) begin
        for (int a = 0; a < 256; a++) ram[k][a] <= INIT_ON ? 8'(a * 37 + 11) : 8'(a);
      end else if (wren_v[k]) begin
        ram[k][addr_v[k]] <= wd_v[k];
      end
      p1[k] <= ram[k][addr_v[k]];
      p2[k] <= p1[k];
    end
  end

  function automatic int n_of(int k);
    case (k) 0: return 4; 3: return 16; default: return 256; endcase
  endfunction

  function automatic int kb_of(int k);
    case (k) 0: return 1; 3: return 5; default: return 3; endcase
  endfunction

  function automatic int exp_lat(int k);
    int base;
    case (k) 0: base = 25; 1: base = 1537; 2: base = 2049; default: base = 97; endcase
    return base + (INIT_ON ? n_of(k) : 0);
  endfunction

  function automatic logic [2047:0] ram_img(int k);
    logic [2047:0] r = '0;
    for (int a = 0; a < n_of(k); a++) r[8*a +: 8] = ram[k][a];
    return r;
  endfunction

  function automatic logic [2047:0] ksa_model(int n, int kb, logic [39:0] kv);
    logic [7:0] s [256];
    logic [7:0] t, kbyte;
    logic [2047:0] r = '0;
    int jj = 0;
    for (int a = 0; a < n; a++) s[a] = 8'(a);
    for (int ii = 0; ii < n; ii++) begin
      kbyte = kv[8*(kb-1-(ii % kb)) +: 8];
      jj = (jj + int'(s[ii]) + int'(kbyte)) % n;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
    end
    for (int a = 0; a < n; a++) r[8*a +: 8] = s[a];
    return r;
  endfunction

  function automatic logic [31:0] keystream4(int k);
    logic [7:0] s [256];
    logic [7:0] t;
    logic [31:0] ks = '0;
    int pi = 0, pj = 0;
    for (int a = 0; a < 256; a++) s[a] = ram[k][a];
    for (int b = 0; b < 4; b++) begin
      pi = (pi + 1) % 256;
      pj = (pj + int'(s[pi])) % 256;
      t = s[pi]; s[pi] = s[pj]; s[pj] = t;
      ks = {ks[23:0], s[8'(s[pi] + s[pj])]};
    end
    return ks;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (done_v[k]) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done inst=%0d cycle=%0d: done seen, none expected", k, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.inst != 2'(k)) begin
            errors++;
            $display("FAIL done_inst: got inst %0d, expected inst %0d", k, mon_e.inst);
          end
          checks++;
          if (32'(cyc - start_cyc[k]) != mon_e.lat) begin
            errors++;
            $display("FAIL latency inst=%0d: got %0d cycles, expected %0d", k, cyc - start_cyc[k], mon_e.lat);
          end
          checks++;
          mon_img = ram_img(k);
          if (mon_img != mon_e.img) begin
            errors++;
            for (int a = 0; a < 256; a++)
              if (mon_img[8*a +: 8] != mon_e.img[8*a +: 8]) begin
                $display("FAIL ram_image inst=%0d entry=%0d: got %0h, expected %0h", k, a, mon_img[8*a +: 8], mon_e.img[8*a +: 8]);
                break;
              end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic preload(input int k);
    fill_k = k;
    fill_go = 1'b1;
    @(negedge clk);
    fill_go = 1'b0;
  endtask

  task automatic set_key(input int k, input logic [39:0] kv);
    case (k)
      0: key0 = kv[7:0];
      1: key1 = kv[23:0];
      2: key2 = kv[23:0];
      default: key3 = kv;
    endcase
  endtask

  task automatic expect_run(input int k, input logic [39:0] kv);
    exp_t e;
    e.inst = 2'(k);
    e.lat  = 32'(exp_lat(k));
    e.img  = ksa_model(n_of(k), kb_of(k), kv);
    sb.push_back(e);
    start_cyc[k] = cyc + 1;
  endtask

  task automatic kick(input int k, input logic [39:0] kv, input bit expect_done);
    preload(k);
    set_key(k, kv);
    if (expect_done) expect_run(k, kv);
    start_v[k] = 1'b1;
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int t = 0;
    while (sb.size() != 0 && t < exp_lat(k) + 20) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout inst=%0d: done not seen within %0d cycles", k, t);
      sb.delete();
    end
  endtask

  initial begin
    logic [2047:0] img_a, img_b;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("reset_out%0d", k),
            64'({busy_v[k], done_v[k], req_v[k], wren_v[k], addr_v[k], wd_v[k]}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // N=4, key 00: hand-computed S = [0,2,3,1]
    kick(0, 40'h00, 1'b1);
    wait_drain(0);
    img_a = ram_img(0);
    check("n4_hand_ram", 64'(img_a[31:0]), 64'h01030200);

    // "Key": standard RC4 keystream begins EB 9F 77 81
    kick(1, 40'h4B6579, 1'b1);
    wait_drain(1);
    check("key_keystream", 64'(keystream4(1)), 64'hEB9F7781);

    kick(2, 40'h4B6579, 1'b1);
    wait_drain(2);
    img_a = ram_img(1);
    img_b = ram_img(2);
    checks++;
    if (img_a != img_b) begin
      errors++;
      $display("FAIL rdlat_equal: got RD_LAT=2 image differing from RD_LAT=1 image, expected identical");
    end

    // Five key bytes with a byte wider than the 4-bit address
    kick(3, 40'hF3071CA955, 1'b1);
    wait_drain(3);

    // Abort in WAIT_J of iteration 100, then a clean rerun
    kick(1, 40'h4B6579, 1'b0);
    repeat ((INIT_ON ? 256 : 0) + 603) @(negedge clk);
    check("busy_before_abort", 64'(busy_v[1]), 64'd1);
    abort_v[1] = 1'b1;
    @(negedge clk);
    abort_v[1] = 1'b0;
    check("abort_idle", 64'({busy_v[1], req_v[1], wren_v[1]}), 64'd0);
    repeat (30) @(negedge clk);
    kick(1, 40'h4B6579, 1'b1);
    wait_drain(1);

    // Abort and start together in IDLE: nothing starts
    set_key(3, 40'h0102030405);
    start_v[3] = 1'b1;
    abort_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;
    abort_v[3] = 1'b0;
    check("abort_start_idle", 64'({busy_v[3], req_v[3]}), 64'd0);
    repeat (5) @(negedge clk);
    check("abort_start_still_idle", 64'(busy_v[3]), 64'd0);

    // Start held high, then a second pulse mid-run: one run, one done
    preload(3);
    set_key(3, 40'h0102030405);
    expect_run(3, 40'h0102030405);
    start_v[3] = 1'b1;
    repeat (40) @(negedge clk);
    check("busy_held_start", 64'(busy_v[3]), 64'd1);
    start_v[3] = 1'b0;
    repeat (10) @(negedge clk);
    start_v[3] = 1'b1;
    @(negedge clk);
    start_v[3] = 1'b0;
    wait_drain(3);
    repeat (5) @(negedge clk);
    check("no_restart", 64'(busy_v[3]), 64'd0);

    // Asynchronous reset mid-run
    kick(3, 40'hF3071CA955, 1'b0);
    repeat (30) @(negedge clk);
    check("busy_before_reset", 64'(busy_v[3]), 64'd1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_out", 64'({busy_v[3], done_v[3], req_v[3], wren_v[3], addr_v[3], wd_v[3]}), 64'd0);
    #4 reset_n = 1'b1;
    @(negedge clk);
    repeat (130) @(negedge clk);
    check("idle_after_reset", 64'(busy_v[3]), 64'd0);
    kick(3, 40'hF3071CA955, 1'b1);
    wait_drain(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
